// File: rtl/spi_shift_engine.sv
// Frame-counting SPI shift engine: parallel-load a TX word, shift it out and RX bits in on strobes.
// Latency: busy the cycle after an accepted start; done is high in the cycle after the Nth shift.
// Backpressure: none; strobes are applied only in SHIFT, and start is only honoured in IDLE (never queued).
// Ports: clk/reset (sync, active-high); start/load_data/frame_len/lsb_first capture a frame;
//        sample_en/shift_en/serial_in drive the bit timing; serial_out/parallel_out/busy/done report.
module spi_shift_engine #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             lsb_first,
    input  logic             sample_en,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] parallel_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem, mem_nxt;
    logic             samp, samp_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic             order, order_nxt;
    logic [LEN_W-1:0] eff_len;
    logic             in_bit;

    // A zero or oversized frame length means a full-width frame.
    always_comb begin
        eff_len = frame_len;
        if (frame_len == '0 || frame_len > WIDTH_L) begin
            eff_len = WIDTH_L;
        end
    end

    // A sample strobe coinciding with a shift bypasses the sample bit so the
    // live serial_in value is shifted in rather than the stale one.
    always_comb in_bit = sample_en ? serial_in : samp;

    always_comb begin
        state_nxt = state;
        mem_nxt   = mem;
        samp_nxt  = samp;
        cnt_nxt   = cnt;
        order_nxt = order;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    mem_nxt   = load_data;
                    cnt_nxt   = eff_len;
                    order_nxt = lsb_first;
                end
            end
            SHIFT: begin
                if (sample_en) begin
                    samp_nxt = serial_in;
                end
                if (shift_en) begin
                    // RX enters at the end opposite to the bit being transmitted.
                    mem_nxt = order ? {in_bit, mem[WIDTH-1:1]} : {mem[WIDTH-2:0], in_bit};
                    cnt_nxt = cnt - ONE_L;
                    if (cnt == ONE_L) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mem   <= '0;
            samp  <= 1'b0;
            cnt   <= '0;
            order <= 1'b0;
        end else begin
            state <= state_nxt;
            mem   <= mem_nxt;
            samp  <= samp_nxt;
            cnt   <= cnt_nxt;
            order <= order_nxt;
        end
    end

    always_comb begin
        serial_out = 1'b0;
        if (state != IDLE) begin
            serial_out = order ? mem[0] : mem[WIDTH-1];
        end
    end

    assign parallel_out = mem;
    assign busy         = (state == SHIFT);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench for spi_shift_engine: stimulus queues expected TX bits and final RX words.
// Latency: monitor checks serial_out on each accepted shift and parallel_out on each done pulse.
// Backpressure: none; stimulus runs on fixed cycle counts, leftovers are flagged at the end.
// Ports: drives every DUT input; observes serial_out, parallel_out, busy and done.
module tb_spi_shift_engine;
    localparam int W  = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  load_data;
    logic [LW-1:0] frame_len;
    logic          lsb_first;
    logic          sample_en;
    logic          shift_en;
    logic          serial_in;
    logic          serial_out;
    logic [W-1:0]  parallel_out;
    logic          busy;
    logic          done;

    spi_shift_engine #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .load_data    (load_data),
        .frame_len    (frame_len),
        .lsb_first    (lsb_first),
        .sample_en    (sample_en),
        .shift_en     (shift_en),
        .serial_in    (serial_in),
        .serial_out   (serial_out),
        .parallel_out (parallel_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    bit           exp_bits[$];
    logic [W-1:0] exp_words[$];
    bit           samp_m   = 1'b0;
    bit           done_due = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_len(input int len_raw);
        return (len_raw == 0 || len_raw > W) ? W : len_raw;
    endfunction

    // Monitor: pops expectations whenever the DUT performs a shift or pulses done.
    always @(negedge clk) begin
        if (!reset) begin
            if (done_due) begin
                check("done_after_last_shift", done, 1);
                done_due = 1'b0;
            end
            if (busy && shift_en) begin
                if (exp_bits.size() == 0) begin
                    check("extra_shift_busy", busy, 0);
                end else begin
                    check("serial_out", serial_out, exp_bits.pop_front());
                    if (exp_bits.size() == 0) done_due = 1'b1;
                end
            end
            if (done) begin
                if (exp_words.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    check("parallel_out", parallel_out, exp_words.pop_front());
                    check("busy_in_done", busy, 0);
                end
            end
            if (!busy && !done) check("idle_serial_out", serial_out, 0);
        end
    end

    // One frame. mode 0: random RX and sampling; 1: RX all ones (bypass); 2: loopback.
    task automatic run_frame(input logic [W-1:0] d, input int len_raw, input bit lsb, input int mode);
        int          len;
        bit          tx[$];
        bit          rx[$];
        bit          byp;
        bit          si;
        bit          b;
        logic [31:0] w;
        len = eff_len(len_raw);
        for (int i = 0; i < len; i++) begin
            b = lsb ? d[i] : d[W-1-i];
            tx.push_back(b);
            exp_bits.push_back(b);
        end
        start     = 1'b1;
        load_data = d;
        frame_len = len_raw[LW-1:0];
        lsb_first = lsb;
        sample_en = 1'b0;
        shift_en  = 1'($urandom % 2);
        serial_in = 1'($urandom % 2);
        step();
        for (int i = 0; i < len; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                start     = ($urandom % 4) == 0;
                load_data = W'($urandom);
                shift_en  = 1'b0;
                serial_in = 1'($urandom % 2);
                sample_en = (mode == 0) && ($urandom % 2 == 1);
                if (sample_en) samp_m = serial_in;
                step();
            end
            byp = (mode == 0) ? 1'($urandom % 2) : 1'b1;
            si  = (mode == 1) ? 1'b1 : (mode == 2) ? tx[i] : 1'($urandom % 2);
            b   = byp ? si : samp_m;
            if (byp) samp_m = si;
            rx.push_back(b);
            if (i == len - 1) begin
                if (!lsb) begin
                    w = 32'(d) << len;
                    for (int k = 0; k < len; k++) w = w | (32'(rx[k]) << (len - 1 - k));
                end else begin
                    w = 32'(d) >> len;
                    for (int k = 0; k < len; k++) w = w | (32'(rx[k]) << (W - len + k));
                end
                exp_words.push_back(w[W-1:0]);
            end
            start     = ($urandom % 4) == 0;
            load_data = W'($urandom);
            shift_en  = 1'b1;
            sample_en = byp;
            serial_in = si;
            step();
        end
        start     = 1'b0;
        shift_en  = 1'b0;
        sample_en = 1'b0;
        step();
        step();
    endtask

    initial begin
        // Reset with everything else held high.
        reset     = 1'b1;
        start     = 1'b1;
        load_data = '1;
        frame_len = '1;
        lsb_first = 1'b1;
        sample_en = 1'b1;
        shift_en  = 1'b1;
        serial_in = 1'b1;
        step();
        step();
        @(negedge clk);
        check("rst_parallel_out", parallel_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_serial_out", serial_out, 0);
        step();
        reset     = 1'b0;
        start     = 1'b0;
        sample_en = 1'b0;
        shift_en  = 1'b0;
        serial_in = 1'b0;
        samp_m    = 1'b0;
        step();

        run_frame(8'hA5, 8, 1'b0, 2);
        run_frame(8'h3C, 8, 1'b1, 1);
        run_frame(8'hB0, 4, 1'b0, 1);
        run_frame(8'h5A, 0, 1'b0, 0);
        run_frame(8'hE7, 0, 1'b1, 0);
        run_frame(8'h81, 13, 1'b0, 0);
        run_frame(8'h6D, 1, 1'b1, 0);

        // Abort: three shifts with a start attempt in the middle, then reset.
        start     = 1'b1;
        load_data = 8'hC3;
        frame_len = '0;
        lsb_first = 1'b0;
        for (int i = 0; i < W; i++) begin
            logic [W-1:0] c3;
            c3 = 8'hC3;
            exp_bits.push_back(c3[W-1-i]);
        end
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            shift_en  = 1'b1;
            sample_en = 1'b1;
            serial_in = 1'b1;
            start     = (i == 1);
            load_data = 8'h00;
            step();
        end
        start     = 1'b0;
        shift_en  = 1'b0;
        sample_en = 1'b0;
        samp_m    = 1'b1;
        @(negedge clk);
        check("busy_mid_frame", busy, 1);
        step();
        reset = 1'b1;
        exp_bits.delete();
        step();
        reset  = 1'b0;
        samp_m = 1'b0;
        @(negedge clk);
        check("abort_parallel_out", parallel_out, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        step();
        step();

        for (int n = 0; n < 40; n++) begin
            run_frame(W'($urandom), $urandom_range(0, 15), 1'($urandom % 2), 0);
        end

        step();
        step();
        check("bits_left", exp_bits.size(), 0);
        check("words_left", exp_words.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
